// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pkg
// Brief  : Shared types and constants for the VGA timing path: lock-state
//          encoding, 1024x768 reference timing (shared with the timing
//          generator) and coordinate / counter widths.
// Rev    : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int XY_W   = 10;  // x / y coordinate and line-counter width
  localparam int HCNT_W = 11;  // horizontal pixel-counter width

  // 1024x768 reference timing
  localparam int H_ACTIVE_1024 = 1024;
  localparam int H_FP_1024     = 16;
  localparam int H_SYNC_1024   = 96;
  localparam int H_BP_1024     = 176;
  localparam int H_TOTAL_1024  = 1312;
  localparam int V_ACTIVE_768  = 768;
  localparam int V_FP_768      = 1;
  localparam int V_SYNC_768    = 3;
  localparam int V_TOTAL_768   = 800;
  localparam int V_BP_768      = V_TOTAL_768 - V_ACTIVE_768 - V_FP_768 - V_SYNC_768;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACKING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_receiver_if.sv
`default_nettype none
// ============================================================================
// Module : vga_sync_receiver_if
// Brief  : Pixel-stream input and recovered-timing output bundle of the VGA
//          sync receiver.
//          master : stream source (drives pix_stb/hsync/vsync/de/pix_in,
//                   observes the recovered outputs)
//          slave  : receiver (samples the stream, drives pix_valid, pix_out,
//                   x, y, line/frame markers, measurements, locked, timeout)
// Rev    : 1.0  initial release
// ============================================================================
interface vga_sync_receiver_if
  import vga_pkg::*;
#(
  parameter int DATA_W = 12
) ();

  logic                pix_stb;
  logic                hsync_in;
  logic                vsync_in;
  logic                de_in;
  logic [DATA_W-1:0]   pix_in;

  logic                pix_valid;
  logic [DATA_W-1:0]   pix_out;
  logic [XY_W-1:0]     x;
  logic [XY_W-1:0]     y;
  logic                line_start;
  logic                frame_start;
  logic [HCNT_W-1:0]   h_total;
  logic [HCNT_W-1:0]   h_active;
  logic [XY_W-1:0]     v_total;
  logic [XY_W-1:0]     v_active;
  logic                locked;
  logic                timeout;

  modport master (
    output pix_stb, hsync_in, vsync_in, de_in, pix_in,
    input  pix_valid, pix_out, x, y, line_start, frame_start,
           h_total, h_active, v_total, v_active, locked, timeout
  );

  modport slave (
    input  pix_stb, hsync_in, vsync_in, de_in, pix_in,
    output pix_valid, pix_out, x, y, line_start, frame_start,
           h_total, h_active, v_total, v_active, locked, timeout
  );

endinterface
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : sync_edge_detect
// Brief  : Normalises one sync/enable input to "1 = asserted" and detects its
//          edges against the previous strobed sample.
//          clk, reset : clock, synchronous active-high reset
//          stb_i      : sample strobe; history register updates only here
//          sig_i      : raw input
//          level_o    : normalised current level (combinational)
//          rise_o     : asserted on a strobed sample that starts a pulse
//          fall_o     : asserted on a strobed sample that ends a pulse
// Rev    : 1.0  initial release
// ============================================================================
module sync_edge_detect #(
  parameter bit POL = 1'b0  // level of the asserted pulse on sig_i
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic stb_i,
  input  wire logic sig_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic prev_q;

  assign level_o = ~(sig_i ^ POL);
  assign rise_o  = stb_i &  level_o & ~prev_q;
  assign fall_o  = stb_i & ~level_o &  prev_q;

  // History starts deasserted so a pulse already present after reset
  // is reported as a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else if (stb_i) begin
      prev_q <= level_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module : vga_sync_receiver
// Brief  : Receive side of the VGA timing interface. Recovers per-pixel x/y,
//          line/frame start markers, measures line and frame timing and
//          reports lock once the measurements are stable.
//          clk, reset : clock, synchronous active-high reset
//          bus        : slave side of vga_sync_receiver_if (stream in,
//                       recovered pixels / measurements / status out)
// Rev    : 1.0  initial release
// ============================================================================
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int DATA_W      = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int H_MAX       = 2047
) (
  input  wire logic          clk,
  input  wire logic          reset,
  vga_sync_receiver_if.slave bus
);

  localparam logic [HCNT_W-1:0] H_LIMIT = HCNT_W'(H_MAX);
  localparam int SNAP_W  = 2 * HCNT_W + 2 * XY_W;
  localparam int MATCH_W = $clog2(LOCK_FRAMES + 2);

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic de_lvl, de_rise, de_fall;

  sync_edge_detect #(.POL(HSYNC_POL)) u_hs (
    .clk(clk), .reset(reset), .stb_i(bus.pix_stb), .sig_i(bus.hsync_in),
    .level_o(hs_lvl), .rise_o(hs_rise), .fall_o(hs_fall));
  sync_edge_detect #(.POL(VSYNC_POL)) u_vs (
    .clk(clk), .reset(reset), .stb_i(bus.pix_stb), .sig_i(bus.vsync_in),
    .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));
  sync_edge_detect #(.POL(1'b1)) u_de (
    .clk(clk), .reset(reset), .stb_i(bus.pix_stb), .sig_i(bus.de_in),
    .level_o(de_lvl), .rise_o(de_rise), .fall_o(de_fall));

  // Only the rising edges of the sync pulses carry timing information.
  logic w_unused;
  assign w_unused = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

  logic                pix_valid_q, pix_valid_d, line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d, frame_pend_q, frame_pend_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   pix_out_q, pix_out_d;
  logic [XY_W-1:0]     x_q, x_d, y_q, y_d, row_q, row_d;
  logic [XY_W-1:0]     act_cnt_q, act_cnt_d, line_cnt_q, line_cnt_d;
  logic [XY_W-1:0]     v_total_q, v_total_d, v_active_q, v_active_d;
  logic [HCNT_W-1:0]   h_cnt_q, h_cnt_d, h_total_q, h_total_d;
  logic [HCNT_W-1:0]   run_q, run_d, h_active_q, h_active_d;
  lock_state_t         state_q, state_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;

  logic                w_de_smp;
  logic [XY_W-1:0]     w_act_base, w_line_base;
  logic [SNAP_W-1:0]   w_snap;
  logic [MATCH_W-1:0]  w_match_inc;

  assign w_de_smp    = bus.pix_stb & de_lvl;
  // A vs edge restarts the active-line count before a coincident de edge
  // is numbered, so that line becomes row 0 of the new frame.
  assign w_act_base  = vs_rise ? '0 : act_cnt_q;
  // A coincident hs edge closes the old frame's last line first.
  assign w_line_base = line_cnt_q + {{(XY_W-1){1'b0}}, hs_rise};
  assign w_snap      = {h_total_d, h_active_d, v_total_d, v_active_d};
  assign w_match_inc = match_q + 1'b1;

  // Data path and timing measurement
  always_comb begin
    pix_valid_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_out_d     = pix_out_q;
    x_d           = x_q;
    y_d           = y_q;
    row_d         = row_q;
    run_d         = run_q;
    h_active_d    = h_active_q;
    act_cnt_d     = act_cnt_q;
    frame_pend_d  = frame_pend_q;
    line_cnt_d    = line_cnt_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    h_cnt_d       = h_cnt_q;
    h_total_d     = h_total_q;
    timeout_d     = timeout_q;

    if (hs_rise) begin
      h_total_d = h_cnt_q;
      h_cnt_d   = HCNT_W'(1);
    end else if (bus.pix_stb) begin
      if (h_cnt_q == H_LIMIT) begin
        timeout_d = 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    if (vs_rise) begin
      v_total_d    = w_line_base;
      v_active_d   = act_cnt_q;
      line_cnt_d   = '0;
      act_cnt_d    = '0;
      frame_pend_d = 1'b1;
    end else begin
      line_cnt_d = w_line_base;
    end

    if (w_de_smp) begin
      pix_valid_d = 1'b1;
      pix_out_d   = bus.pix_in;
      if (de_rise) begin
        x_d           = '0;
        y_d           = w_act_base;
        row_d         = w_act_base;
        act_cnt_d     = w_act_base + 1'b1;
        run_d         = HCNT_W'(1);
        line_start_d  = 1'b1;
        frame_start_d = vs_rise | frame_pend_q;
        frame_pend_d  = 1'b0;
      end else begin
        x_d   = run_q[XY_W-1:0];
        y_d   = row_q;
        run_d = run_q + 1'b1;
      end
    end

    if (de_fall) begin
      h_active_d = run_q;
    end
  end

  // Lock tracking, evaluated once per frame on the vs edge
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    snap_d  = snap_q;
    if (vs_rise) begin
      case (state_q)
        ST_UNLOCKED: begin
          snap_d  = w_snap;
          match_d = MATCH_W'(1);
          state_d = ST_TRACKING;
        end
        ST_TRACKING: begin
          if (w_snap == snap_q) begin
            if (32'(w_match_inc) >= LOCK_FRAMES) begin
              // A stream that has ever overrun a line is never trusted
              // again until reset.
              if (!timeout_q) state_d = ST_LOCKED;
            end else begin
              match_d = w_match_inc;
            end
          end else begin
            snap_d  = w_snap;
            match_d = MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          if (w_snap != snap_q || timeout_q) state_d = ST_UNLOCKED;
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;  line_start_q <= 1'b0;  frame_start_q <= 1'b0;
      frame_pend_q <= 1'b0; timeout_q <= 1'b0;     pix_out_q <= '0;
      x_q <= '0;  y_q <= '0;  row_q <= '0;  act_cnt_q <= '0;  line_cnt_q <= '0;
      v_total_q <= '0;  v_active_q <= '0;  h_cnt_q <= '0;  h_total_q <= '0;
      run_q <= '0;  h_active_q <= '0;
      state_q <= ST_UNLOCKED;  match_q <= '0;  snap_q <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;  line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;  frame_pend_q <= frame_pend_d;
      timeout_q <= timeout_d;  pix_out_q <= pix_out_d;
      x_q <= x_d;  y_q <= y_d;  row_q <= row_d;  act_cnt_q <= act_cnt_d;
      line_cnt_q <= line_cnt_d;  v_total_q <= v_total_d;  v_active_q <= v_active_d;
      h_cnt_q <= h_cnt_d;  h_total_q <= h_total_d;  run_q <= run_d;
      h_active_q <= h_active_d;
      state_q <= state_d;  match_q <= match_d;  snap_q <= snap_d;
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_out     = pix_out_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.h_total     = h_total_q;
  assign bus.h_active    = h_active_q;
  assign bus.v_total     = v_total_q;
  assign bus.v_active    = v_active_q;
  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_sync_receiver
// Brief  : Bench for vga_sync_receiver. A reduced test raster (20 pixels per
//          line: 2 hsync, 2 back porch, 12 active, 4 front porch; 10 lines per
//          frame: 2 vsync, 6 active, 2 blank; pix_stb every second clk) is
//          fed to an active-low-sync and an active-high-sync instance.
//          Pixel data carries {row[5:0], col[5:0]} so recovered x/y can be
//          checked against the data they arrive with.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_sync_receiver;

  localparam int DW    = 12;
  localparam int HMAXB = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_receiver_if #(.DATA_W(DW)) bus_n ();
  vga_sync_receiver_if #(.DATA_W(DW)) bus_p ();

  vga_sync_receiver #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .DATA_W(DW),
                      .LOCK_FRAMES(2), .H_MAX(HMAXB))
    dut_n (.clk(clk), .reset(reset), .bus(bus_n));
  vga_sync_receiver #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DATA_W(DW),
                      .LOCK_FRAMES(2), .H_MAX(HMAXB))
    dut_p (.clk(clk), .reset(reset), .bus(bus_p));

  int n_pass  = 0;
  int n_total = 0;
  int cur_line = 0;
  bit mon_en = 1'b0;
  int cnt_pv, cnt_ls, cnt_fs;

  typedef struct {
    int nl;                 // lines to send from cur_line
    bit lng;                // line 9 of each frame is 21 pixels long
    int ht, ha, vt, va;     // expected measurements afterwards
    bit lk;                 // expected locked
    int pv, ls, fs;         // expected pix_valid / line_start / frame_start counts
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit stb, input bit hs, input bit vs, input bit de,
                       input logic [DW-1:0] d);
    bus_n.pix_stb = stb;  bus_n.hsync_in = ~hs;  bus_n.vsync_in = ~vs;
    bus_n.de_in = de;     bus_n.pix_in = d;
    bus_p.pix_stb = stb;  bus_p.hsync_in = hs;   bus_p.vsync_in = vs;
    bus_p.de_in = de;     bus_p.pix_in = d;
  endtask

  task automatic send_pix(input bit hs, input bit vs, input bit de,
                          input logic [DW-1:0] d);
    @(negedge clk) drive(1'b1, hs, vs, de, d);
    @(negedge clk) drive(1'b0, hs, vs, de, d);
  endtask

  task automatic send_line(input int l, input int len, input int p0, input int p1);
    for (int p = p0; p < p1; p++) begin
      bit de;
      de = (l >= 2) && (l < 8) && (p >= 4) && (p < 16);
      send_pix(p < 2, l < 2, de, {6'(l - 2), 6'(p - 4)});
    end
    if (len < 0) $display("unreachable");
  endtask

  task automatic send_lines(input int n, input bit lng);
    for (int i = 0; i < n; i++) begin
      send_line(cur_line, (lng && cur_line == 9) ? 21 : 20, 0,
                (lng && cur_line == 9) ? 21 : 20);
      cur_line = (cur_line + 1) % 10;
    end
  endtask

  task automatic clear_counts();
    cnt_pv = 0;  cnt_ls = 0;  cnt_fs = 0;
  endtask

  task automatic chk_meas(input string t, input int ht, input int ha,
                          input int vt, input int va, input bit lk, input bit to);
    chk({t, " h_total"},  int'(bus_n.h_total),  ht);
    chk({t, " h_active"}, int'(bus_n.h_active), ha);
    chk({t, " v_total"},  int'(bus_n.v_total),  vt);
    chk({t, " v_active"}, int'(bus_n.v_active), va);
    chk({t, " locked"},   int'(bus_n.locked),   int'(lk));
    chk({t, " timeout"},  int'(bus_n.timeout),  int'(to));
    chk({t, " pol h_total"},  int'(bus_p.h_total),  ht);
    chk({t, " pol h_active"}, int'(bus_p.h_active), ha);
    chk({t, " pol v_total"},  int'(bus_p.v_total),  vt);
    chk({t, " pol v_active"}, int'(bus_p.v_active), va);
    chk({t, " pol locked"},   int'(bus_p.locked),   int'(lk));
    chk({t, " pol timeout"},  int'(bus_p.timeout),  int'(to));
  endtask

  task automatic chk_zero(input string t);
    chk({t, " pix_valid"},   int'(bus_n.pix_valid),   0);
    chk({t, " pix_out"},     int'(bus_n.pix_out),     0);
    chk({t, " x"},           int'(bus_n.x),           0);
    chk({t, " y"},           int'(bus_n.y),           0);
    chk({t, " line_start"},  int'(bus_n.line_start),  0);
    chk({t, " frame_start"}, int'(bus_n.frame_start), 0);
    chk_meas(t, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Pixel monitor: recovered x/y must match the coordinates embedded in
  // the pixel data they travel with.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_n.pix_valid) begin
        cnt_pv++;
        chk("pix_x", int'(bus_n.x), int'(bus_n.pix_out[5:0]));
        chk("pix_y", int'(bus_n.y), int'(bus_n.pix_out[11:6]));
      end
      if (bus_n.line_start) begin
        cnt_ls++;
        chk("line_start_x0", int'(bus_n.x), 0);
        chk("line_start_valid", int'(bus_n.pix_valid), 1);
      end
      if (bus_n.frame_start) begin
        cnt_fs++;
        chk("frame_start_y0", int'(bus_n.y), 0);
        chk("frame_start_line_start", int'(bus_n.line_start), 1);
      end
    end
  end

  initial begin
    //          nl  lng  ht  ha  vt va  lk  pv ls fs
    tbl[0] = '{10, 1'b0, 20, 12, 1,  0, 1'b0, 72, 6, 1};  // partial first frame
    tbl[1] = '{10, 1'b0, 20, 12, 10, 6, 1'b0, 72, 6, 1};
    tbl[2] = '{10, 1'b0, 20, 12, 10, 6, 1'b1, 72, 6, 1};  // third vs edge locks
    tbl[3] = '{10, 1'b1, 20, 12, 10, 6, 1'b1, 72, 6, 1};  // last line 21 pixels
    tbl[4] = '{1,  1'b0, 21, 12, 10, 6, 1'b0, 0,  0, 0};  // long line seen, unlock
    tbl[5] = '{9,  1'b0, 20, 12, 10, 6, 1'b0, 72, 6, 1};
    tbl[6] = '{10, 1'b0, 20, 12, 10, 6, 1'b0, 72, 6, 1};
    tbl[7] = '{10, 1'b0, 20, 12, 10, 6, 1'b1, 72, 6, 1};  // relocked

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    clear_counts();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    mon_en = 1'b1;
    foreach (tbl[i]) begin
      clear_counts();
      send_lines(tbl[i].nl, tbl[i].lng);
      chk_meas($sformatf("vec%0d", i), tbl[i].ht, tbl[i].ha, tbl[i].vt,
               tbl[i].va, tbl[i].lk, 1'b0);
      chk($sformatf("vec%0d pix_valid count", i), cnt_pv, tbl[i].pv);
      chk($sformatf("vec%0d line_start count", i), cnt_ls, tbl[i].ls);
      chk($sformatf("vec%0d frame_start count", i), cnt_fs, tbl[i].fs);
    end

    // Timeout: after line 9 the counter holds 20; 20 idle pixels reach the
    // ceiling of 40, the 21st overruns it.
    repeat (20) send_pix(1'b0, 1'b0, 1'b0, '0);
    chk("timeout at ceiling", int'(bus_n.timeout), 0);
    send_pix(1'b0, 1'b0, 1'b0, '0);
    chk("timeout past ceiling", int'(bus_n.timeout), 1);
    chk("pol timeout past ceiling", int'(bus_p.timeout), 1);
    repeat (29) send_pix(1'b0, 1'b0, 1'b0, '0);
    send_lines(30, 1'b0);
    chk_meas("after timeout", 20, 12, 10, 6, 1'b0, 1'b1);

    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk_zero("reset clears timeout");
    reset = 1'b0;

    // Mid-frame reset at line 5, pixel 8
    clear_counts();
    send_lines(10, 1'b0);
    chk_meas("post-reset frame", 20, 12, 1, 0, 1'b0, 1'b0);
    send_lines(5, 1'b0);
    send_line(5, 20, 0, 8);
    mon_en = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk_zero("mid-frame reset");
    reset = 1'b0;
    send_line(5, 20, 8, 20);
    cur_line = 6;
    send_lines(4, 1'b0);
    chk("v_total held after reset", int'(bus_n.v_total), 0);
    clear_counts();
    mon_en = 1'b1;
    send_lines(10, 1'b0);
    chk("partial v_total", int'(bus_n.v_total), 5);
    chk("partial v_active", int'(bus_n.v_active), 3);
    chk("frame pix_valid count", cnt_pv, 72);
    chk("frame line_start count", cnt_ls, 6);
    chk("frame frame_start count", cnt_fs, 1);
    send_lines(10, 1'b0);
    chk_meas("recovered", 20, 12, 10, 6, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
